// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port integer register file.
package rf_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;

  typedef logic [4:0] rf_addr_t;

  typedef struct packed {
    logic                  en;
    rf_addr_t              addr;
    logic [DATA_W_DEF-1:0] data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: decode reservations set them, writeback writes clear them.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  output logic [NUM_REGS-1:0]          busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Reservation is applied after the releases so a new producer outranks a same-cycle write.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && addr_ok(wr_addr[i])) busy_d[wr_addr[i]] = 1'b0;
    end
    if (rsv_en && addr_ok(rsv_addr)) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    busy_vec = busy_q;
    if (ZERO_REG != 0) busy_vec[0] = 1'b0;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with optional zero register, write-to-read bypass and busy scoreboard.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic                           rsv_en,
  input  logic [AW-1:0]                  rsv_addr,
  output logic [NUM_REGS-1:0]            busy_vec
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Ports are applied in ascending order so the highest-index port wins a conflict.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && addr_ok(wr_addr[i])) mem_d[wr_addr[i]] = wr_data[i];
    end
    if (ZERO_REG != 0) mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      if (addr_ok(rd_addr[j])) begin
        rd_data[j] = mem_q[rd_addr[j]];
        rd_busy[j] = busy_vec[rd_addr[j]];
        if (BYPASS != 0) begin
          for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && (wr_addr[i] == rd_addr[j])) begin
              rd_data[j] = wr_data[i];
              rd_busy[j] = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a write-first and a read-first instance share one stimulus.
module tb_reg_file_mp;

  localparam int NR = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0][4:0]  rd_addr;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             rsv_en;
  logic [4:0]       rsv_addr;

  logic [1:0][31:0] b_rd_data, f_rd_data;
  logic [1:0]       b_rd_busy, f_rd_busy;
  logic [NR-1:0]    b_busy_vec, f_busy_vec;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(b_busy_vec));

  reg_file_mp #(.DATA_W(32), .NUM_REGS(NR), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(f_rd_data), .rd_busy(f_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(f_busy_vec));

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); rd_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd_addr[0] = 5'(a); rd_addr[1] = 5'(31 - a);
      #1;
      checks++; if (b_rd_data !== '0 || f_rd_data !== '0) $display("FAIL reset_data a=%0d: got %h/%h want 0", a, b_rd_data, f_rd_data); else passes++;
      checks++; if (b_rd_busy !== '0 || f_rd_busy !== '0) $display("FAIL reset_busy a=%0d: got %b/%b want 0", a, b_rd_busy, f_rd_busy); else passes++;
    end
    checks++; if (b_busy_vec !== '0 || f_busy_vec !== '0) $display("FAIL reset_busy_vec: got %h/%h want 0", b_busy_vec, f_busy_vec); else passes++;
    next();
  endtask

  task automatic test_write_read();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5'd5;
    #1;
    checks++; if (b_rd_data[0] !== 32'hDEADBEEF) $display("FAIL wr_bypass: got %h want deadbeef", b_rd_data[0]); else passes++;
    checks++; if (f_rd_data[0] !== 32'h0) $display("FAIL wr_readfirst: got %h want 00000000", f_rd_data[0]); else passes++;
    next();
    #1;
    checks++; if (b_rd_data[0] !== 32'hDEADBEEF || f_rd_data[0] !== 32'hDEADBEEF) $display("FAIL wr_next: got %h/%h want deadbeef", b_rd_data[0], f_rd_data[0]); else passes++;
    next();
  endtask

  task automatic test_zero_reg();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'h12345678; rd_addr = '0;
    #1;
    checks++; if (b_rd_data[0] !== 32'h0) $display("FAIL zero_bypass: got %h want 0", b_rd_data[0]); else passes++;
    next();
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    checks++; if (b_rd_data[0] !== 32'h0 || f_rd_data[0] !== 32'h0) $display("FAIL zero_read: got %h/%h want 0", b_rd_data[0], f_rd_data[0]); else passes++;
    next();
    #1;
    checks++; if (b_busy_vec[0] !== 1'b0 || f_busy_vec[0] !== 1'b0) $display("FAIL zero_busy_vec: got %b/%b want 0", b_busy_vec[0], f_busy_vec[0]); else passes++;
    checks++; if (b_rd_busy[0] !== 1'b0) $display("FAIL zero_rd_busy: got %b want 0", b_rd_busy[0]); else passes++;
    next();
  endtask

  task automatic test_reserve();
    rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
    #1;
    checks++; if (b_rd_busy[0] !== 1'b0) $display("FAIL rsv_same_cycle: got %b want 0", b_rd_busy[0]); else passes++;
    next();
    #1;
    checks++; if (b_rd_busy[1] !== 1'b1 || b_busy_vec[7] !== 1'b1) $display("FAIL rsv_busy: got %b/%b want 1/1", b_rd_busy[1], b_busy_vec[7]); else passes++;
    wr_en[1] = 1'b1; wr_addr[1] = 5'd7; wr_data[1] = 32'hA5A5A5A5;
    #1;
    checks++; if (b_rd_data[0] !== 32'hA5A5A5A5 || b_rd_busy[0] !== 1'b0) $display("FAIL rsv_wr_bypass: got %h/%b want a5a5a5a5/0", b_rd_data[0], b_rd_busy[0]); else passes++;
    checks++; if (f_rd_data[0] !== 32'h0 || f_rd_busy[0] !== 1'b1) $display("FAIL rsv_wr_readfirst: got %h/%b want 00000000/1", f_rd_data[0], f_rd_busy[0]); else passes++;
    next();
    #1;
    checks++; if (b_busy_vec[7] !== 1'b0 || f_busy_vec[7] !== 1'b0) $display("FAIL rsv_release: got %b/%b want 0", b_busy_vec[7], f_busy_vec[7]); else passes++;
    checks++; if (f_rd_data[1] !== 32'hA5A5A5A5) $display("FAIL rsv_data: got %h want a5a5a5a5", f_rd_data[1]); else passes++;
    next();
  endtask

  task automatic test_ww_conflict();
    wr_en = 2'b11; wr_addr[0] = 5'd9; wr_addr[1] = 5'd9;
    wr_data[0] = 32'h1111; wr_data[1] = 32'h2222; rd_addr[0] = 5'd9;
    #1;
    checks++; if (b_rd_data[0] !== 32'h2222) $display("FAIL ww_bypass: got %h want 00002222", b_rd_data[0]); else passes++;
    next();
    #1;
    checks++; if (b_rd_data[0] !== 32'h2222 || f_rd_data[0] !== 32'h2222) $display("FAIL ww_stored: got %h/%h want 00002222", b_rd_data[0], f_rd_data[0]); else passes++;
    rsv_en = 1'b1; rsv_addr = 5'd9; wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h3333;
    next();
    #1;
    checks++; if (f_rd_data[0] !== 32'h3333 || b_rd_data[0] !== 32'h3333) $display("FAIL rsvwr_data: got %h/%h want 00003333", b_rd_data[0], f_rd_data[0]); else passes++;
    checks++; if (b_busy_vec[9] !== 1'b1 || b_rd_busy[0] !== 1'b1) $display("FAIL rsvwr_busy: got %b/%b want 1/1", b_busy_vec[9], b_rd_busy[0]); else passes++;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h4444;
    next();
    #1;
    checks++; if (b_busy_vec !== '0) $display("FAIL ww_release: got %h want 0", b_busy_vec); else passes++;
    next();
  endtask

  task automatic test_out_of_range();
    wr_en = 2'b11; wr_addr[0] = 5'd30; wr_data[0] = 32'hFFFFFFFF;
    wr_addr[1] = 5'd23; wr_data[1] = 32'hCAFEF00D;
    rsv_en = 1'b1; rsv_addr = 5'd30; rd_addr[0] = 5'd30; rd_addr[1] = 5'd23;
    #1;
    checks++; if (b_rd_data[0] !== 32'h0 || b_rd_busy[0] !== 1'b0) $display("FAIL oor_bypass: got %h/%b want 0/0", b_rd_data[0], b_rd_busy[0]); else passes++;
    checks++; if (b_rd_data[1] !== 32'hCAFEF00D) $display("FAIL top_reg_bypass: got %h want cafef00d", b_rd_data[1]); else passes++;
    next();
    rd_addr[0] = 5'd24;
    #1;
    checks++; if (b_busy_vec !== '0 || f_busy_vec !== '0) $display("FAIL oor_rsv: got %h/%h want 0", b_busy_vec, f_busy_vec); else passes++;
    checks++; if (f_rd_data[0] !== 32'h0 || f_rd_busy[0] !== 1'b0) $display("FAIL oor_read24: got %h/%b want 0/0", f_rd_data[0], f_rd_busy[0]); else passes++;
    checks++; if (f_rd_data[1] !== 32'hCAFEF00D) $display("FAIL top_reg_stored: got %h want cafef00d", f_rd_data[1]); else passes++;
    rd_addr[0] = 5'd30;
    #1;
    checks++; if (f_rd_data[0] !== 32'h0) $display("FAIL oor_read30: got %h want 0", f_rd_data[0]); else passes++;
    next();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      wr_en[0] = 1'b1; wr_addr[0] = 5'(10 + k); wr_data[0] = 32'(k + 1) * 32'h0101;
      rd_addr[1] = 5'(10 + k - 1);
      #1;
      if (k > 0) begin
        checks++; if (f_rd_data[1] !== 32'(k) * 32'h0101) $display("FAIL b2b k=%0d: got %h want %h", k, f_rd_data[1], 32'(k) * 32'h0101); else passes++;
      end
      next();
    end
  endtask

  task automatic test_reset_mid();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    next();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'h55;
    next();
    rd_addr[0] = 5'd4;
    #1;
    checks++; if (f_busy_vec !== 24'h000008 || f_rd_data[0] !== 32'h55) $display("FAIL pre_reset: got %h/%h want 000008/00000055", f_busy_vec, f_rd_data[0]); else passes++;
    rst_n = 1'b0; wr_en[1] = 1'b1; wr_addr[1] = 5'd6; wr_data[1] = 32'h66; rsv_en = 1'b1; rsv_addr = 5'd8;
    next();
    rst_n = 1'b1;
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
    #1;
    checks++; if (b_rd_data !== '0 || f_rd_data !== '0 || b_rd_busy !== '0) $display("FAIL post_reset_r3r4: got %h/%h/%b want 0", b_rd_data, f_rd_data, b_rd_busy); else passes++;
    rd_addr[0] = 5'd6; rd_addr[1] = 5'd7;
    #1;
    checks++; if (b_rd_data !== '0 || f_rd_data !== '0) $display("FAIL post_reset_r6r7: got %h/%h want 0", b_rd_data, f_rd_data); else passes++;
    checks++; if (b_busy_vec !== '0 || f_busy_vec !== '0) $display("FAIL post_reset_busy: got %h/%h want 0", b_busy_vec, f_busy_vec); else passes++;
    next();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; idle(); rd_addr = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_reserve();
    test_ww_conflict();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
